// File: rtl/pipe_ctrl_unit_pkg.sv
// pipe_ctrl_unit_pkg: opcodes, ALUOp codes, control-word layout and FSM states for the ID-stage control unit.
package pipe_ctrl_unit_pkg;
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [1:0] ALU_R   = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_EXT = 2'b11;
   typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_TRAP} state_t;
   typedef struct packed {
      logic       jump;
      logic [1:0] branch;
      logic       reg_write;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_w;
      logic       mem_r;
      logic       mem_to_reg;
   } ctrl_t;
endpackage

// File: rtl/pipe_ctrl_unit_opcode_decode.sv
// opcode_decode: combinational opcode -> {control word, undefined flag, rt-is-source flag}.
// EXT_OPS_EN adds andi/slti/lui with ALUOp=11; without it those opcodes are undefined.
module opcode_decode
   import pipe_ctrl_unit_pkg::*;
(
   input  logic [5:0]  op,
   output logic [10:0] ctrl,
   output logic        undef,
   output logic        uses_rt
);
   ctrl_t c;
   always_comb begin
      c = '0;
      undef = 1'b0;
      case (op)
         OP_R:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_R; end
         OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_ORI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR; end
         OP_LW:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; c.mem_r = 1'b1; c.mem_to_reg = 1'b1; end
         OP_SW:   begin c.alu_src = 1'b1; c.alu_op = ALU_ADD; c.mem_w = 1'b1; end
         OP_BEQ:  c.branch = 2'b01;
         OP_BNE:  c.branch = 2'b11;
         OP_J:    c.jump = 1'b1;
`ifdef EXT_OPS_EN
         OP_ANDI, OP_SLTI, OP_LUI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_EXT; end
`endif
         default: undef = 1'b1;
      endcase
   end
   assign ctrl = c;
   assign uses_rt = op inside {OP_R, OP_BEQ, OP_BNE, OP_SW};
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: registered ID-stage control with load-use interlock, branch flush and undefined-op trap.
// Optional EXT_OPS_EN (see opcode_decode) enables the andi/slti/lui decode.
module pipe_ctrl_unit
   import pipe_ctrl_unit_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_SLOTS  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Inst_valid,
   input  logic [31:0]       Inst,
   input  logic              Ex_MemR,
   input  logic [REG_AW-1:0] Ex_Rt,
   input  logic              BranchTaken,
   input  logic              Hold,
   input  logic              Trap_ack,
   output logic [10:0]       Ctrl,
   output logic              Ctrl_valid,
   output logic              Stall,
   output logic              Flush,
   output logic              UndefInst,
   output logic              Trap_pending
);
   state_t state;
   logic [1:0] cnt;
   logic [10:0] dec_ctrl;
   logic dec_undef, dec_uses_rt, hazard, in_run;
   logic [REG_AW-1:0] rs, rt;
   logic unused_imm;
   opcode_decode u_dec (
      .op(Inst[31:26]),
      .ctrl(dec_ctrl),
      .undef(dec_undef),
      .uses_rt(dec_uses_rt)
   );
   assign rs = Inst[25 -: REG_AW];
   assign rt = Inst[20 -: REG_AW];
   assign unused_imm = ^Inst[15:0];
   assign in_run = state == S_RUN;
   // rt only counts as a source for R-type, branches and stores
   assign hazard = Ex_MemR && Ex_Rt != '0 && (Ex_Rt == rs || (Ex_Rt == rt && dec_uses_rt));
   assign Stall = Hold || state == S_TRAP || (!BranchTaken && (state == S_STALL || (in_run && Inst_valid && hazard)));
   assign Flush = !Hold && (state == S_TRAP ? Trap_ack : (BranchTaken || state == S_FLUSH));
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_RUN;
         cnt <= 2'd0;
         Ctrl <= '0;
         Ctrl_valid <= 1'b0;
         UndefInst <= 1'b0;
         Trap_pending <= 1'b0;
      end else if (Hold) begin
         UndefInst <= 1'b0;
      end else begin
         Ctrl <= '0;
         Ctrl_valid <= 1'b0;
         UndefInst <= 1'b0;
         if (state == S_TRAP) begin
            if (Trap_ack) begin
               state <= S_RUN;
               Trap_pending <= 1'b0;
            end
         end else if (BranchTaken) begin
            state <= FLUSH_SLOTS > 1 ? S_FLUSH : S_RUN;
            cnt <= 2'(FLUSH_SLOTS - 1);
         end else if (!in_run) begin
            state <= cnt == 2'd1 ? S_RUN : state;
            cnt <= cnt - 2'd1;
         end else if (Inst_valid && hazard) begin
            state <= STALL_CYCLES > 1 ? S_STALL : S_RUN;
            cnt <= 2'(STALL_CYCLES - 1);
         end else if (Inst_valid && dec_undef) begin
            state <= S_TRAP;
            UndefInst <= 1'b1;
            Trap_pending <= 1'b1;
         end else if (Inst_valid) begin
            Ctrl <= dec_ctrl;
            Ctrl_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: three configurations driven in lockstep, checked against a vector table and a behavioural model.
module tb_pipe_ctrl_unit;
   localparam int N = 3;
   logic clk = 1'b0;
   logic rst_n, inst_valid, ex_memr, bt, hold, ack;
   logic [31:0] inst;
   logic [4:0] ex_rt;
   logic [N-1:0][10:0] ctrl;
   logic [N-1:0] cv, stall, flush, undef, tp;
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      bit rst_n, valid;
      logic [31:0] inst;
      bit memr;
      logic [4:0] rt;
      bit bt, hold, ack, s, f;
      logic [10:0] ctrl;
      bit cv, ud, tp;
   } vec_t;

   typedef struct {
      int stall_left, flush_left;
      bit trap;
      logic [10:0] ctrl;
      bit cv, ud, tp;
   } mst_t;
   mst_t m[N];

   pipe_ctrl_unit #(.REG_AW(5), .STALL_CYCLES(2), .FLUSH_SLOTS(2)) u_a (
      .clk(clk), .rst_n(rst_n), .Inst_valid(inst_valid), .Inst(inst), .Ex_MemR(ex_memr), .Ex_Rt(ex_rt),
      .BranchTaken(bt), .Hold(hold), .Trap_ack(ack), .Ctrl(ctrl[0]), .Ctrl_valid(cv[0]), .Stall(stall[0]),
      .Flush(flush[0]), .UndefInst(undef[0]), .Trap_pending(tp[0]));
   pipe_ctrl_unit #(.REG_AW(5), .STALL_CYCLES(3), .FLUSH_SLOTS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .Inst_valid(inst_valid), .Inst(inst), .Ex_MemR(ex_memr), .Ex_Rt(ex_rt),
      .BranchTaken(bt), .Hold(hold), .Trap_ack(ack), .Ctrl(ctrl[1]), .Ctrl_valid(cv[1]), .Stall(stall[1]),
      .Flush(flush[1]), .UndefInst(undef[1]), .Trap_pending(tp[1]));
   pipe_ctrl_unit #(.REG_AW(5), .STALL_CYCLES(1), .FLUSH_SLOTS(1)) u_c (
      .clk(clk), .rst_n(rst_n), .Inst_valid(inst_valid), .Inst(inst), .Ex_MemR(ex_memr), .Ex_Rt(ex_rt),
      .BranchTaken(bt), .Hold(hold), .Trap_ack(ack), .Ctrl(ctrl[2]), .Ctrl_valid(cv[2]), .Stall(stall[2]),
      .Flush(flush[2]), .UndefInst(undef[2]), .Trap_pending(tp[2]));

   always #5 clk = ~clk;

   function automatic int sc_of(input int i);
      return i == 0 ? 2 : i == 1 ? 3 : 1;
   endfunction
   function automatic int fs_of(input int i);
      return i == 2 ? 1 : 2;
   endfunction

   // Control word assembled field by field from the opcode table
   function automatic logic [10:0] ref_decode(input logic [5:0] op, output bit bad);
      logic jump, rw, as, rd, mw, mr, mtr;
      logic [1:0] br, aop;
      {jump, rw, as, rd, mw, mr, mtr} = '0;
      br = 2'b00;
      aop = 2'b00;
      bad = 1'b0;
      if (op == 6'h00) begin rw = 1; rd = 1; end
      else if (op == 6'h08) begin rw = 1; as = 1; aop = 2'd1; end
      else if (op == 6'h0D) begin rw = 1; as = 1; aop = 2'd2; end
      else if (op == 6'h23) begin rw = 1; as = 1; aop = 2'd1; mr = 1; mtr = 1; end
      else if (op == 6'h2B) begin as = 1; aop = 2'd1; mw = 1; end
      else if (op == 6'h04) br = 2'b01;
      else if (op == 6'h05) br = 2'b11;
      else if (op == 6'h02) jump = 1;
`ifdef EXT_OPS_EN
      else if (op == 6'h0C || op == 6'h0A || op == 6'h0F) begin rw = 1; as = 1; aop = 2'd3; end
`endif
      else bad = 1'b1;
      return {jump, br, rw, as, aop, rd, mw, mr, mtr};
   endfunction

   function automatic bit ref_hazard();
      logic [5:0] op;
      op = inst[31:26];
      return ex_memr && ex_rt != 0 &&
             (ex_rt == inst[25:21] || (ex_rt == inst[20:16] && (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B)));
   endfunction

   task automatic model_comb(input int i, output bit s, output bit f);
      if (hold) begin s = 1; f = 0; end
      else if (m[i].trap) begin s = 1; f = ack; end
      else if (bt) begin s = 0; f = 1; end
      else if (m[i].flush_left > 0) begin s = 0; f = 1; end
      else if (m[i].stall_left > 0) begin s = 1; f = 0; end
      else begin s = inst_valid && ref_hazard(); f = 0; end
   endtask

   task automatic model_next(input int i);
      bit bad;
      logic [10:0] d;
      d = ref_decode(inst[31:26], bad);
      if (!rst_n) begin
         m[i].stall_left = 0; m[i].flush_left = 0; m[i].trap = 0;
         m[i].ctrl = 0; m[i].cv = 0; m[i].ud = 0; m[i].tp = 0;
      end else if (hold) begin
         m[i].ud = 0;
      end else begin
         m[i].ctrl = 0; m[i].cv = 0; m[i].ud = 0;
         if (m[i].trap) begin
            if (ack) begin m[i].trap = 0; m[i].tp = 0; end
         end else if (bt) begin
            m[i].flush_left = fs_of(i) - 1;
            m[i].stall_left = 0;
         end else if (m[i].flush_left > 0) m[i].flush_left--;
         else if (m[i].stall_left > 0) m[i].stall_left--;
         else if (inst_valid && ref_hazard()) m[i].stall_left = sc_of(i) - 1;
         else if (inst_valid && bad) begin m[i].ud = 1; m[i].tp = 1; m[i].trap = 1; end
         else if (inst_valid) begin m[i].ctrl = d; m[i].cv = 1; end
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] I(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
      return {op, rs, rt, 16'h1234};
   endfunction

   function automatic vec_t V(input bit r, input bit v, input logic [31:0] in, input bit mr, input logic [4:0] ert,
                              input bit b, input bit h, input bit a, input bit s, input bit f,
                              input logic [10:0] c, input bit cval, input bit ud, input bit tpe);
      vec_t x;
      x.rst_n = r; x.valid = v; x.inst = in; x.memr = mr; x.rt = ert; x.bt = b; x.hold = h; x.ack = a;
      x.s = s; x.f = f; x.ctrl = c; x.cv = cval; x.ud = ud; x.tp = tpe;
      return x;
   endfunction

   // One clock: drive at negedge, check combinational outputs mid-low, registered outputs after the edge
   task automatic cycle(input int di, input string tag, input vec_t v);
      bit s, f;
      rst_n = v.rst_n; inst_valid = v.valid; inst = v.inst; ex_memr = v.memr; ex_rt = v.rt;
      bt = v.bt; hold = v.hold; ack = v.ack;
      #1;
      for (int i = 0; i < N; i++) if (rst_n) begin
         model_comb(i, s, f);
         chk($sformatf("%s model d%0d stall/flush", tag, i), 16'({stall[i], flush[i]}), 16'({s, f}));
      end
      if (di >= 0 && v.rst_n)
         chk($sformatf("%s vec d%0d stall/flush", tag, di), 16'({stall[di], flush[di]}), 16'({v.s, v.f}));
      @(posedge clk);
      for (int i = 0; i < N; i++) model_next(i);
      #1;
      for (int i = 0; i < N; i++)
         chk($sformatf("%s model d%0d ctrl/cv/ud/tp", tag, i), 16'({ctrl[i], cv[i], undef[i], tp[i]}),
             16'({m[i].ctrl, m[i].cv, m[i].ud, m[i].tp}));
      if (di >= 0)
         chk($sformatf("%s vec d%0d ctrl/cv/ud/tp", tag, di), 16'({ctrl[di], cv[di], undef[di], tp[di]}),
             16'({v.ctrl, v.cv, v.ud, v.tp}));
      @(negedge clk);
   endtask

   vec_t tab[$];
   vec_t rv;
   logic [5:0] ops[14];

   initial begin
      // r v inst             mr rt bt h a  s f  ctrl  cv ud tp
      tab.push_back(V(0, 0, I(6'h00, 0, 0), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h0D0, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h23, 1, 3), 0, 0, 0, 0, 0, 0, 0, 11'h0D3, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 5, 6), 0, 5, 0, 0, 0, 0, 0, 11'h088, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 0, 0), 1, 0, 0, 0, 0, 0, 0, 11'h088, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h2B, 1, 5), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h2B, 1, 5), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h2B, 1, 5), 0, 5, 0, 0, 0, 0, 0, 11'h054, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h08, 1, 5), 1, 5, 0, 0, 0, 0, 0, 11'h0D0, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h04, 1, 2), 0, 0, 1, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h0D, 1, 2), 0, 0, 0, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h0D, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h0E0, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h05, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h300, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h04, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h100, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h02, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h400, 1, 0, 0));
      tab.push_back(V(1, 0, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h3F, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 1, 1));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 1, 0, 11'h000, 0, 0, 1));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 1, 0, 0, 1, 0, 11'h000, 0, 0, 1));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 1, 1, 1, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h0D0, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h3F, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 1, 1));
      tab.push_back(V(0, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h0D0, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      for (int k = 0; k < 4; k++)
         tab.push_back(V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 1, 0, 1, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 1, I(6'h00, 5, 6), 0, 5, 0, 0, 0, 0, 0, 11'h088, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 1, 0, 1, 0, 11'h088, 1, 0, 0));
      tab.push_back(V(1, 1, I(6'h3F, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 1, 1));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 1, 0, 1, 0, 11'h000, 0, 0, 1));
      tab.push_back(V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 1, 1, 1, 11'h000, 0, 0, 0));
      tab.push_back(V(1, 0, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0));

      @(negedge clk);
      foreach (tab[k]) cycle(0, $sformatf("row%0d", k), tab[k]);

      // trap holds the pipe until acknowledged
      cycle(0, "trap_in", V(1, 1, I(6'h3F, 2, 3), 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 1, 1));
      for (int k = 0; k < 10; k++)
         cycle(0, $sformatf("trap_wait%0d", k), V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 1, 0, 11'h000, 0, 0, 1));
      cycle(0, "trap_ack", V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 1, 1, 1, 11'h000, 0, 0, 0));

      // 3-cycle stall cancelled by a branch, then a flush restarted by a second branch
      cycle(1, "b_stall", V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0));
      cycle(1, "b_br", V(1, 1, I(6'h00, 5, 6), 1, 5, 1, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      cycle(1, "b_fl", V(1, 1, I(6'h00, 5, 6), 1, 5, 0, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      cycle(1, "b_run", V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h0D0, 1, 0, 0));
      cycle(1, "b_br1", V(1, 1, I(6'h08, 1, 2), 0, 0, 1, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      cycle(1, "b_br2", V(1, 1, I(6'h08, 1, 2), 0, 0, 1, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      cycle(1, "b_fl2", V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 1, 11'h000, 0, 0, 0));
      cycle(1, "b_run2", V(1, 1, I(6'h08, 1, 2), 0, 0, 0, 0, 0, 0, 0, 11'h0D0, 1, 0, 0));

      ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h0A, 6'h0C, 6'h0F, 6'h3F, 6'h23, 6'h00};
      for (int k = 0; k < 3000; k++) begin
         rv.rst_n = $urandom_range(0, 63) != 0;
         rv.valid = $urandom_range(0, 3) != 0;
         rv.inst = I(($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)],
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         rv.memr = $urandom_range(0, 1) != 0;
         rv.rt = 5'($urandom_range(0, 7));
         rv.bt = $urandom_range(0, 7) == 0;
         rv.hold = $urandom_range(0, 7) == 0;
         rv.ack = $urandom_range(0, 3) == 0;
         cycle(-1, $sformatf("rnd%0d", k), rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
